// File: rtl/ring_meas_pkg.sv
// Shared types and defaults for the ring-oscillator frequency meter.
// Holds the FSM state encoding and the default window and width settings.
package ring_meas_pkg;

  localparam int GATE_CYCLES_D   = 1024;
  localparam int SETTLE_CYCLES_D = 16;
  localparam int CNT_W_D         = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    DONE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus delay flop for an asynchronous input.
// rise is high for one clk cycle per synchronized rising edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ring_freq_meter.sv
// Measures ring-oscillator edges over a fixed clk window after a start-up wait.
// The result is held with valid until the consumer acknowledges it.
module ring_freq_meter
  import ring_meas_pkg::*;
#(
  parameter int GATE_CYCLES   = GATE_CYCLES_D,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_D,
  parameter int CNT_W         = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ack,
  input  logic             ring_clk,
  output logic             ring_en,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int WIN_W =
    $clog2(max2(GATE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [WIN_W-1:0] SET_LAST =
    WIN_W'(SETTLE_CYCLES - 1);
  localparam logic [WIN_W-1:0] GATE_LAST =
    WIN_W'(GATE_CYCLES - 1);

  state_t           r_state;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_edge;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_valid;
  logic             r_busy;
  logic             r_ring_en;

  logic             w_rise;
  logic [CNT_W-1:0] w_edge_nxt;
  logic             w_ovf_nxt;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ring_clk),
    .rise     (w_rise)
  );

  // Saturating edge count; an edge at full scale only raises overflow.
  always_comb begin
    w_edge_nxt = r_edge;
    w_ovf_nxt  = r_ovf;
    if (w_rise) begin
      if (&r_edge) w_ovf_nxt = 1'b1;
      else         w_edge_nxt = r_edge + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_win      <= '0;
      r_edge     <= '0;
      r_ovf      <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_ring_en  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= SETTLE;
            r_win      <= '0;
            r_edge     <= '0;
            r_ovf      <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_ring_en  <= 1'b1;
          end
        end
        SETTLE: begin
          if (r_win == SET_LAST) begin
            r_win   <= '0;
            r_state <= GATE;
          end else begin
            r_win <= r_win + 1'b1;
          end
        end
        GATE: begin
          r_edge <= w_edge_nxt;
          r_ovf  <= w_ovf_nxt;
          if (r_win == GATE_LAST) begin
            r_state    <= DONE;
            r_count    <= w_edge_nxt;
            r_overflow <= w_ovf_nxt;
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
            r_ring_en  <= 1'b0;
          end else begin
            r_win <= r_win + 1'b1;
          end
        end
        DONE: begin
          if (ack) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ring_en  = r_ring_en;
  assign busy     = r_busy;
  assign valid    = r_valid;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
